// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the MIPS execution-stage ALU.
// Holds the 4-bit ALU control codes (also consumed by the ALU control
// decoder so both sides agree on one encoding) and the FSM state encoding
// used by alu_exec_unit.
package alu_exec_unit_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    // Execution FSM states
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

endpackage

// File: rtl/alu_exec_unit_iter_multiplier.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        load operands, clear accumulator and iteration counter
//   run_i          perform one iteration this cycle
//   mcand_i        multiplicand loaded on start_i
//   mplier_i       multiplier loaded on start_i
//   last_o         the iteration performed this cycle is the final one
//   acc_next_o     accumulator value after this cycle's iteration; equals the
//                  low WIDTH bits of the product when last_o is high
module alu_exec_unit_iter_multiplier #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_next_o
);

    localparam int unsigned Iters = WIDTH / MUL_BITS;
    localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] partial;

    // multiplicand x low MUL_BITS of multiplier, built from shifted copies
    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    assign acc_next_o = acc_q + partial;
    assign last_o     = run_i && (cnt_q == CntW'(Iters - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (run_i) begin
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            acc_d    = acc_next_o;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU for the pipelined MIPS core.
// Single-cycle AND/OR/ADD/SUB/SLT, iterative MUL with a pipeline stall.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        request valid; sampled together with ctrl_i/src*_i when ready_o
//   ready_o        unit can accept a request this cycle
//   ctrl_i         4-bit ALU control code
//   src1_i, src2_i operands A and B
//   result_o       registered result, held until the next completion
//   zero_o         result_o == 0, registered with result_o
//   done_o         one-cycle completion pulse
//   stall_o        high while a MUL is iterating
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             stall_o
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] simple_res;
    logic             accept;
    logic             mul_start;
    logic             mul_run;
    logic             mul_last;
    logic [WIDTH-1:0] mul_acc_next;

    assign ready_o   = (state_q == ST_IDLE);
    assign stall_o   = (state_q == ST_MUL_RUN);
    assign accept    = valid_i && ready_o;
    assign mul_start = accept && (ctrl_i == ALU_MUL);
    assign mul_run   = (state_q == ST_MUL_RUN);

    // Undefined codes (and MUL, which never uses this path) yield zero.
    always_comb begin
        unique case (ctrl_i)
            ALU_AND: simple_res = src1_i & src2_i;
            ALU_OR:  simple_res = src1_i | src2_i;
            ALU_ADD: simple_res = src1_i + src2_i;
            ALU_SUB: simple_res = src1_i - src2_i;
            ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            default: simple_res = '0;
        endcase
    end

    alu_exec_unit_iter_multiplier #(
        .WIDTH   (WIDTH),
        .MUL_BITS(MUL_BITS)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .run_i     (mul_run),
        .mcand_i   (src1_i),
        .mplier_i  (src2_i),
        .last_o    (mul_last),
        .acc_next_o(mul_acc_next)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL_RUN;
                end else if (accept) begin
                    result_d = simple_res;
                    zero_d   = (simple_res == '0);
                    done_d   = 1'b1;
                end
            end
            ST_MUL_RUN: begin
                // Final iteration's sum goes straight into the output register.
                if (mul_last) begin
                    result_d = mul_acc_next;
                    zero_d   = (mul_acc_next == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] src1, src2;
    logic        ready, zero, done, stall;
    logic [31:0] result;
    logic        ready4, zero4, done4, stall4;
    logic [31:0] result4;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t sb4[$];
    exp_t e;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .ready_o (ready),
        .ctrl_i  (ctrl),
        .src1_i  (src1),
        .src2_i  (src2),
        .result_o(result),
        .zero_o  (zero),
        .done_o  (done),
        .stall_o (stall)
    );

    // Same stimulus, 4 multiplier bits per iteration.
    alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .ready_o (ready4),
        .ctrl_i  (ctrl),
        .src1_i  (src1),
        .src2_i  (src2),
        .result_o(result4),
        .zero_o  (zero4),
        .done_o  (done4),
        .stall_o (stall4)
    );

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t r;
        case (c)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0010: r.res = a + b;
            4'b0110: r.res = a - b;
            4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r.res = a * b;
            default: r.res = 32'd0;
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        valid = v;
        ctrl  = c;
        src1  = a;
        src2  = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h zero=%b done=%b expected 0/1/0",
                     result, zero, done);
        end
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got ready=%b stall=%b expected 1/0", ready, stall);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b done=%b expected 1/0", ready, done);
        end
    endtask

    task automatic test_add();
        drive(1'b1, 4'b0010, 32'h5, 32'h3);
        sb.push_back(model(4'b0010, 32'h5, 32'h3));
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL add_done: got %b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero || result !== 32'h8) begin
                errors++;
                $display("FAIL add_result: got %h/%b expected %h/%b", result, zero, e.res, e.zero);
            end
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  c[4];
        logic [31:0] a[4];
        logic [31:0] b[4];
        c[0] = 4'b0110; a[0] = 32'h7;        b[0] = 32'h7;
        c[1] = 4'b0111; a[1] = 32'hFFFFFFFF; b[1] = 32'h1;
        c[2] = 4'b0000; a[2] = 32'hF0F0F0F0; b[2] = 32'h0FF00FF0;
        c[3] = 4'b0001; a[3] = 32'hF0000000; b[3] = 32'h0000000F;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done[%0d]: got %b expected 1", i - 1, done);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (result !== e.res || zero !== e.zero) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b",
                                 i - 1, result, zero, e.res, e.zero);
                    end
                end
            end
            if (i < 4) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready);
                end
                drive(1'b1, c[i], a[i], b[i]);
                sb.push_back(model(c[i], a[i], b[i]));
            end else begin
                drive(1'b0, 4'b0000, 32'h0, 32'h0);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_done: got %b expected 0", done);
        end
        sb.delete();
    endtask

    // Checks both instances: MUL_BITS=1 completes on cycle 33, MUL_BITS=4 on cycle 9.
    task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] golden);
        drive(1'b1, 4'b1000, a, b);
        sb.push_back(model(4'b1000, a, b));
        sb4.push_back(model(4'b1000, a, b));
        checks++;
        if (model(4'b1000, a, b).res !== golden) begin
            errors++;
            $display("FAIL mul_model: got %h expected %h", model(4'b1000, a, b).res, golden);
        end
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            drive(1'b0, 4'b0000, 32'h0, 32'h0);
            if (cyc <= 32) begin
                checks++;
                if (stall !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_busy[%0d]: got stall=%b ready=%b done=%b expected 1/0/0",
                             cyc, stall, ready, done);
                end
            end else if (cyc == 33) begin
                checks++;
                if (done !== 1'b1 || stall !== 1'b0 || ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_done: got done=%b stall=%b ready=%b expected 1/0/1",
                             done, stall, ready);
                end
                if (done === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (result !== e.res || zero !== e.zero) begin
                        errors++;
                        $display("FAIL mul_result: got %h/%b expected %h/%b",
                                 result, zero, e.res, e.zero);
                    end
                end
            end else if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL mul_extra_done[%0d]: got %b expected 0", cyc, done);
            end
            if (cyc < 9 || cyc > 9) begin
                if (done4 !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL mul4_early_done[%0d]: got %b expected 0", cyc, done4);
                end
            end else begin
                checks++;
                if (done4 !== 1'b1) begin
                    errors++;
                    $display("FAIL mul4_done: got %b expected 1", done4);
                end else begin
                    e = sb4.pop_front();
                    checks++;
                    if (result4 !== e.res || zero4 !== e.zero) begin
                        errors++;
                        $display("FAIL mul4_result: got %h/%b expected %h/%b",
                                 result4, zero4, e.res, e.zero);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || sb4.size() != 0) begin
            errors++;
            $display("FAIL mul_missing: got %0d/%0d pending expected 0/0", sb.size(), sb4.size());
        end
        sb.delete();
        sb4.delete();
    endtask

    task automatic test_undefined();
        drive(1'b1, 4'b1111, 32'h5, 32'h3);
        sb.push_back(model(4'b1111, 32'h5, 32'h3));
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL undef_done: got %b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero) begin
                errors++;
                $display("FAIL undef_result: got %h/%b expected %h/%b", result, zero, e.res, e.zero);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL undef_single_pulse: got %b expected 0", done);
        end
        sb.delete();
    endtask

    task automatic test_ignore_busy();
        int n_done = 0;
        drive(1'b1, 4'b1000, 32'h3, 32'h5);
        sb.push_back(model(4'b1000, 32'h3, 32'h5));
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (cyc != 33 || sb.size() == 0) begin
                    errors++;
                    $display("FAIL busy_done_cycle: got cycle %0d expected 33", cyc);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res || zero !== e.zero) begin
                        errors++;
                        $display("FAIL busy_result: got %h/%b expected %h/%b",
                                 result, zero, e.res, e.zero);
                    end
                end
            end
            if (cyc == 5) drive(1'b1, 4'b0010, 32'h1, 32'h1);
            else drive(1'b0, 4'b0000, 32'h0, 32'h0);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d expected 1", n_done);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_mul();
        int n_done = 0;
        drive(1'b1, 4'b1000, 32'h1234, 32'h5678);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            drive(1'b0, 4'b0000, 32'h0, 32'h0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got result=%h zero=%b done=%b expected 0/1/0",
                     result, zero, done);
        end
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_handshake: got ready=%b stall=%b expected 1/0", ready, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: got ready=%b stall=%b done=%b expected 1/0/0",
                     ready, stall, done);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0 || result !== 32'h0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d pulses result=%h expected 0 pulses result=0",
                     n_done, result);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        test_reset();
        test_add();
        test_back_to_back();
        test_mul(32'h00001234, 32'h00005678, 32'h06260060);
        test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        test_undefined();
        test_ignore_busy();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage arithmetic unit for the pipelined MIPS core.
- It consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands, and returns a registered result.
- Simple ops (AND/OR/ADD/SUB/SLT) complete in one cycle. MUL (code 4'b1000) runs as an iterative shift-add sequence.
- While MUL runs, the unit asserts a stall to the hazard unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MUL_BITS, 1, multiplier bits retired per iteration. Legal values are 1, 2 and 4; WIDTH must be divisible by MUL_BITS.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid; ctrl_i/src1_i/src2_i sampled when valid_i && ready_o.
- ready_o  output  1  unit can accept a request this cycle.
- ctrl_i  input  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- result_o  output  WIDTH  registered result; held until next completion.
- zero_o  output  1  result_o == 0, registered with result_o.
- done_o  output  1  one-cycle pulse; result_o/zero_o valid from this cycle.
- stall_o  output  1  high while a MUL is in flight (the accept cycle is excluded).

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; result_o=0; zero_o=1; done_o=0; ready_o=1; stall_o=0.
  - Iteration counter and accumulators are cleared.
- States: IDLE, MUL_RUN.
- IDLE:
  - ready_o=1.
  - On accept with a non-MUL code: result computed combinationally, registered at the same edge, done_o=1 next cycle. Latency is 1 cycle, and back-to-back accepts are allowed every cycle.
  - On accept with ctrl_i=1000: latch multiplicand=src1_i and multiplier=src2_i, clear the accumulator and counter, go to MUL_RUN.
- MUL_RUN:
  - ready_o=0; stall_o=1.
  - Each cycle, add (multiplicand × low MUL_BITS of multiplier) to the accumulator, shift the multiplicand left by MUL_BITS, shift the multiplier right by MUL_BITS, and increment the counter.
  - After WIDTH/MUL_BITS iterations: result_o = low WIDTH bits of the product, done_o=1, return to IDLE.
  - Total latency is WIDTH/MUL_BITS+1 cycles from accept to done_o (33 for defaults).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
  - SLT is a signed compare giving 1 or 0 zero-extended.
  - MUL returns the low WIDTH bits, which are identical for signed and unsigned operands.
- Undefined ctrl_i codes: result_o=0, zero_o=1, done_o pulses. Treated as a 1-cycle op.
- valid_i while ready_o=0 is ignored. The requester holds the request, and the pipeline guarantees this via stall_o.
- done_o is never high on two consecutive cycles for the same request. It is high for consecutive cycles only for consecutive single-cycle requests.
- result_o/zero_o change only on a completion edge or reset.
- Reset mid-MUL aborts the operation immediately: no done_o, outputs go to reset values, next cycle is in IDLE.
- A request accepted on the same edge that a MUL completes cannot happen, because ready_o=0 in MUL_RUN.

Decomposition:
- Shared package holds:
  - ALU control code constants (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_MUL=4'b1000).
  - State encoding (IDLE, MUL_RUN).
  - Shared with the ALU control decoder so the codes have a single source.
- One sub-module is natural: iter_multiplier, containing the shift-add datapath, iteration counter and its done flag. The top level holds the FSM, the simple-op datapath and the output registers.

Test Plan:
- Reset, then ADD src1=0x00000005 src2=0x00000003 -> next cycle done_o=1, result_o=0x00000008, zero_o=0.
- Back-to-back one per cycle:
  - SUB 7-7 -> result 0, zero_o=1.
  - SLT 0xFFFFFFFF,0x00000001 -> result 1.
  - AND 0xF0F0F0F0,0x0FF00FF0 -> 0x00F000F0.
  - OR 0xF0000000,0x0000000F -> 0xF000000F.
  - done_o high on each of the 4 cycles.
- MUL 0x00001234 × 0x00005678 -> ready_o=0 and stall_o=1 for 32 cycles, done_o on cycle 33, result 0x06260060.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> result 0x00000001; with MUL_BITS=4 done_o is on cycle 9.
- Assert rst_i at MUL iteration 10 -> result_o=0, zero_o=1, no done_o, ready_o=1 on the cycle after release.
- Undefined code 4'b1111 -> done_o next cycle, result_o=0, zero_o=1; a valid_i pulse during MUL_RUN is ignored and produces no extra done_o.
